// File: rtl/tlb_arb_pkg.sv
// tlb_arb_pkg: shared definitions for the TLB lookup arbiter.
//   state_t   : arbiter FSM encoding
//   req_id_t  : requester identity (IF / LS)
//   TLB_ADDR_W, TLB_DATA_W : default bus widths of the shared TLB
package tlb_arb_pkg;

  localparam int TLB_ADDR_W = 6;
  localparam int TLB_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_t;

endpackage

// File: rtl/tlb_rr_pick.sv
// tlb_rr_pick: two-input round-robin picker, purely combinational.
//   req_if, req_ls : requests from instruction fetch / load-store
//   prio           : requester preferred when both ask
//   winner         : selected requester (don't care when any == 0)
//   any            : at least one request present
module tlb_rr_pick
  import tlb_arb_pkg::*;
(
  input  logic    req_if,
  input  logic    req_ls,
  input  req_id_t prio,
  output req_id_t winner,
  output logic    any
);

  always_comb begin
    winner = REQ_IF;
    if (req_if && req_ls) winner = prio;
    else if (req_ls)      winner = REQ_LS;
  end

  assign any = req_if | req_ls;

endmodule

// File: rtl/tlb_arbiter.sv
// tlb_arbiter: shares one combinational TLB between the IF and LS units.
//   Clock, Resetn          : clock (rising edge), async active-low reset
//   ifReq/ifAddr/ifGnt     : IF request handshake (Gnt is a one-cycle pulse)
//   ifValid/ifData/ifAck   : IF response, held until acknowledged
//   ls*                    : same for the load/store unit
//   tlbAddr                : registered address to the TLB
//   tlbData                : TLB output, combinational from tlbAddr
// One transaction at a time: IDLE (grant) -> LOOKUP (capture) -> RESP (wait Ack).
module tlb_arbiter
  import tlb_arb_pkg::*;
#(
  parameter int ADDR_W = TLB_ADDR_W,
  parameter int DATA_W = TLB_DATA_W
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic              ifGnt,
  output logic              ifValid,
  output logic [DATA_W-1:0] ifData,
  input  logic              ifAck,
  input  logic              lsReq,
  input  logic [ADDR_W-1:0] lsAddr,
  output logic              lsGnt,
  output logic              lsValid,
  output logic [DATA_W-1:0] lsData,
  input  logic              lsAck,
  output logic [ADDR_W-1:0] tlbAddr,
  input  logic [DATA_W-1:0] tlbData
);

  state_t  state, state_nxt;
  req_id_t owner, prio, winner;
  logic    any, grant, capture, done, owner_ack;

  tlb_rr_pick u_pick (
    .req_if (ifReq),
    .req_ls (lsReq),
    .prio   (prio),
    .winner (winner),
    .any    (any)
  );

  // Acks from the non-owner are never looked at.
  assign owner_ack = (owner == REQ_LS) ? lsAck : ifAck;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (any) begin
        grant     = 1'b1;
        state_nxt = LOOKUP;
      end
      LOOKUP: begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: if (owner_ack) begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      owner   <= REQ_IF;
      prio    <= REQ_IF;
      tlbAddr <= '0;
      ifGnt   <= 1'b0;
      lsGnt   <= 1'b0;
      ifValid <= 1'b0;
      lsValid <= 1'b0;
      ifData  <= '0;
      lsData  <= '0;
    end else begin
      ifGnt <= grant && (winner == REQ_IF);
      lsGnt <= grant && (winner == REQ_LS);
      if (grant) begin
        owner   <= winner;
        tlbAddr <= (winner == REQ_LS) ? lsAddr : ifAddr;
      end
      // Data registers load only here, so they stay stable through RESP
      // and keep the last translation after Valid drops.
      if (capture) begin
        if (owner == REQ_LS) begin
          lsData  <= tlbData;
          lsValid <= 1'b1;
        end else begin
          ifData  <= tlbData;
          ifValid <= 1'b1;
        end
      end
      if (done) begin
        if (owner == REQ_LS) lsValid <= 1'b0;
        else                 ifValid <= 1'b0;
        prio <= (owner == REQ_LS) ? REQ_IF : REQ_LS;
      end
    end
  end

endmodule

// File: tb/tb_tlb_arbiter.sv
// tb_tlb_arbiter: directed plan steps followed by randomized traffic, all
// checked cycle by cycle against a transaction-level reference model.
module tb_tlb_arbiter;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        ifReq, ifAck, lsReq, lsAck;
  logic [5:0]  ifAddr, lsAddr, tlbAddr;
  logic        ifGnt, ifValid, lsGnt, lsValid;
  logic [15:0] ifData, lsData, tlbData;

  tlb_arbiter dut (
    .Clock(Clock), .Resetn(Resetn),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifGnt(ifGnt), .ifValid(ifValid),
    .ifData(ifData), .ifAck(ifAck),
    .lsReq(lsReq), .lsAddr(lsAddr), .lsGnt(lsGnt), .lsValid(lsValid),
    .lsData(lsData), .lsAck(lsAck),
    .tlbAddr(tlbAddr), .tlbData(tlbData)
  );

  always #5 Clock = ~Clock;

  // TLB stand-in: 40 mapped entries, everything above misses (0).
  // noise corrupts the TLB output whenever no capture is due, so a
  // capture at the wrong time or a non-holding Data register shows up.
  logic [15:0] rom [0:63];
  logic [15:0] noise = '0;
  assign tlbData = rom[tlbAddr] ^ noise;

  // Reference model: index 0 = IF, 1 = LS.
  int          m_phase;   // 0 idle, 1 granted/looking up, 2 responding
  int          m_owner, m_prio;
  logic [5:0]  m_addr;
  logic        m_gnt [2];
  logic        m_valid [2];
  logic [15:0] m_data [2];
  logic        keep_req [2];

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_prio = 0; m_addr = '0;
    for (int i = 0; i < 2; i++) begin
      m_gnt[i] = 1'b0; m_valid[i] = 1'b0; m_data[i] = '0;
    end
  endtask

  task automatic model_edge();
    logic ack_owner;
    if (!Resetn) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: begin
        m_gnt[0] = 1'b0; m_gnt[1] = 1'b0;
        if (ifReq || lsReq) begin
          m_owner = (ifReq && lsReq) ? m_prio : (lsReq ? 1 : 0);
          m_addr  = (m_owner == 1) ? lsAddr : ifAddr;
          m_gnt[m_owner] = 1'b1;
          m_phase = 1;
        end
      end
      1: begin
        m_gnt[0] = 1'b0; m_gnt[1] = 1'b0;
        m_data[m_owner]  = rom[m_addr];
        m_valid[m_owner] = 1'b1;
        m_phase = 2;
      end
      default: begin
        ack_owner = (m_owner == 1) ? lsAck : ifAck;
        if (ack_owner) begin
          m_valid[m_owner] = 1'b0;
          m_prio  = 1 - m_owner;
          m_phase = 0;
        end
      end
    endcase
  endtask

  task automatic check_all();
    chk("ifGnt",   ifGnt,   m_gnt[0]);
    chk("lsGnt",   lsGnt,   m_gnt[1]);
    chk("ifValid", ifValid, m_valid[0]);
    chk("lsValid", lsValid, m_valid[1]);
    chk("ifData",  ifData,  m_data[0]);
    chk("lsData",  lsData,  m_data[1]);
    chk("tlbAddr", tlbAddr, m_addr);
  endtask

  // One clock: model follows the edge, outputs checked 1 time unit later,
  // granted requests are withdrawn unless asked to stay high.
  task automatic step();
    @(posedge Clock);
    model_edge();
    #1;
    check_all();
    if (m_gnt[0] && !keep_req[0]) ifReq = 1'b0;
    if (m_gnt[1] && !keep_req[1]) lsReq = 1'b0;
    noise = (m_phase == 1) ? 16'h0000 : 16'($urandom);
  endtask

  initial begin
    for (int a = 0; a < 64; a++) rom[a] = (a < 40) ? 16'(a * 16'h0351 + 16'h1003) : 16'h0000;
    rom[0] = 16'h0040; rom[1] = 16'h0002; rom[4] = 16'h0580; rom[37] = 16'h2180;

    keep_req[0] = 1'b0; keep_req[1] = 1'b0;
    ifReq = 0; lsReq = 0; ifAck = 0; lsAck = 0; ifAddr = '0; lsAddr = '0;
    Resetn = 1'b1;
    #2 Resetn = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge Clock);
    Resetn = 1'b1;

    // Both request together from reset: IF first, then LS.
    ifReq = 1; ifAddr = 6'd0; lsReq = 1; lsAddr = 6'd1;
    step(); chk("rr_if_first", ifGnt, 1'b1);
    step(); chk("rr_if_data", ifData, 16'h0040);
    ifAck = 1; step(); ifAck = 0;
    step(); chk("rr_ls_second", lsGnt, 1'b1);
    step(); chk("rr_ls_data", lsData, 16'h0002);
    lsAck = 1; step(); lsAck = 0;

    // IF alone, address 4.
    ifReq = 1; ifAddr = 6'd4;
    step(); chk("if4_gnt", ifGnt, 1'b1); chk("if4_addr", tlbAddr, 6'd4);
    step(); chk("if4_gnt_pulse", ifGnt, 1'b0); chk("if4_data", ifData, 16'h0580);
    chk("if4_valid", ifValid, 1'b1); chk("if4_ls_quiet", lsValid, 1'b0);
    ifAck = 1; step(); ifAck = 0;

    // Both again: IF was served last, so LS now wins.
    ifReq = 1; ifAddr = 6'd0; lsReq = 1; lsAddr = 6'd1;
    step(); chk("rr_ls_wins", lsGnt, 1'b1);
    step(); lsAck = 1; step(); lsAck = 0;
    step(); chk("rr_if_after", ifGnt, 1'b1);
    step(); ifAck = 1; step(); ifAck = 0;

    // LS 37 with Ack withheld; IF raised during RESP waits, and misses.
    lsReq = 1; lsAddr = 6'd37;
    step(); step();
    ifReq = 1; ifAddr = 6'd40;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ls37_hold", lsData, 16'h2180);
      chk("ls37_if_wait", ifGnt, 1'b0);
    end
    lsAck = 1; step(); lsAck = 0;
    step(); chk("miss_gnt", ifGnt, 1'b1);
    step(); chk("miss_data", ifData, 16'h0000); chk("miss_valid", ifValid, 1'b1);
    // Spurious acks: LS ack while IF owns RESP, IF ack in IDLE.
    lsAck = 1; step(); step(); lsAck = 0;
    chk("spur_if_valid", ifValid, 1'b1);
    ifAck = 1; step(); ifAck = 0;
    ifAck = 1; step(); step(); ifAck = 0;

    // Reset in LOOKUP aborts the lookup; IF priority restored.
    lsReq = 1; lsAddr = 6'd9;
    step();
    Resetn = 1'b0;
    #1 model_reset();
    check_all();
    chk("rst_lsgnt", lsGnt, 1'b0);
    lsReq = 0;
    step(); step();
    Resetn = 1'b1;
    step(); chk("rst_no_resp", lsValid, 1'b0);
    ifReq = 1; ifAddr = 6'd2; lsReq = 1; lsAddr = 6'd3;
    step(); chk("rst_if_prio", ifGnt, 1'b1);
    step(); ifAck = 1; step(); ifAck = 0;
    step(); step(); lsAck = 1; step(); lsAck = 0;

    // Randomized traffic obeying the request protocol.
    for (int c = 0; c < 600; c++) begin
      if (!ifReq && ($urandom_range(9) < 3)) begin
        ifReq = 1; ifAddr = 6'($urandom_range(47));
      end
      if (!lsReq && ($urandom_range(9) < 3)) begin
        lsReq = 1; lsAddr = 6'($urandom_range(47));
      end
      keep_req[0] = ($urandom_range(3) == 0);
      keep_req[1] = ($urandom_range(3) == 0);
      ifAck = ($urandom_range(9) < 4);
      lsAck = ($urandom_range(9) < 4);
      step();
    end
    ifReq = 0; lsReq = 0; ifAck = 0; lsAck = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/tlb_arbiter.md
# tlb_arbiter

Shares the single combinational TLB/instruction-translation lookup between two requesters: the instruction-fetch unit (IF) and the load/store unit (LS). Each requester presents a 6-bit virtual address with a request/grant handshake. The arbiter registers the winning address onto the TLB address bus and captures the 16-bit translation one cycle later. It then holds the result on that requester's response port until acknowledged. It sits between the processor control FSM and the TLB, and is the only driver of the TLB `addr` input.

## Interface
- `ADDR_W`, 6, virtual address width (TLB `addr` width)
- `DATA_W`, 16, translation/instruction word width (TLB `out` width)
- `Clock`  in  1  single system clock, rising edge
- `Resetn`  in  1  reset, asynchronous, active-low
- `ifReq`  in  1  IF request; held high with `ifAddr` stable until `ifGnt`
- `ifAddr`  in  ADDR_W  IF virtual address
- `ifGnt`  out  1  one-cycle pulse: IF request accepted
- `ifValid`  out  1  `ifData` valid; held until `ifAck`
- `ifData`  out  DATA_W  translated word for IF
- `ifAck`  in  1  IF consumes response
- `lsReq`, `lsAddr`, `lsGnt`, `lsValid`, `lsData`, `lsAck`: same as IF, for LS
- `tlbAddr`  out  ADDR_W  registered address to TLB `addr`
- `tlbData`  in  DATA_W  TLB `out`, combinational from `tlbAddr`

## Operation
- FSM states: IDLE, LOOKUP, RESP.
  - IDLE: at an edge with any request high, pick the winner, load `tlbAddr` from its address, record the owner ID, set its Gnt, go to LOOKUP. With no request, stay in IDLE.
  - LOOKUP: at the next edge, capture `tlbData` into the owner's Data register, set the owner's Valid, go to RESP.
  - RESP: at an edge with the owner's Ack high, clear Valid, toggle priority away from the owner, go to IDLE. Otherwise hold.
- Arbitration is round-robin between the two requesters:
  - Priority pointer resets to prefer IF.
  - A single requester always wins.
  - When both requests are high, the non-preferred requester is the one served last.
- Only one transaction is outstanding at a time. The losing requester keeps its Req high and is served in the next IDLE.
- Requests are not sampled outside IDLE. A Req still high after its Gnt is treated as a new request at the next IDLE.
- An Ack outside RESP, or from the non-owner, is ignored.
- A TLB miss returns the TLB's 16'h0000. It is passed through unchanged; no miss signalling.
- The Data registers hold their last captured value after Valid drops; they change only on capture.

## Timing
- Reset (asynchronous, Resetn low) sets:
  - state IDLE;
  - `tlbAddr`=0;
  - `ifGnt`, `lsGnt`, `ifValid`, `lsValid` = 0;
  - `ifData`, `lsData` = 0;
  - priority = IF.
- Reset mid-transaction aborts it; no response is ever produced for that transaction.
- All outputs are registered; no combinational path from any input to any output.
- Latency, for a request sampled at edge k in IDLE:
  - Gnt high during cycle k..k+1 (one cycle);
  - `tlbAddr` valid from edge k;
  - Valid and Data from edge k+1.
- Minimum occupancy is 3 edges per transaction, with Ack high the first cycle Valid is high. The next grant occurs at edge k+3 at the earliest.
- Valid stays high indefinitely until Ack.
- Data is stable while Valid is high, even if `tlbData` changes.

## Structure
- Shared package `tlb_arb_pkg` contains:
  - state encoding (IDLE=2'd0, LOOKUP=2'd1, RESP=2'd2);
  - requester IDs (REQ_IF=1'b0, REQ_LS=1'b1);
  - `ADDR_W`/`DATA_W` defaults.
- One sub-module: `tlb_rr_pick`, a two-input round-robin picker. Inputs: two requests and the priority pointer. Outputs: a winner ID and an any-request flag. Purely combinational.
- The FSM, address register and response registers stay in `tlb_arbiter`. The TLB is instantiated by the parent, not inside the arbiter.

## Test plan
- Reset then IF only, `ifAddr`=6'd4 → `ifGnt` pulses one cycle, `tlbAddr`=4, then `ifValid`=1 with `ifData`=16'h0580 one edge later; `lsValid` stays 0.
- IF and LS requests in the same cycle, `ifAddr`=0, `lsAddr`=1 → IF is served first with 16'h0040; after `ifAck`, LS is served with 16'h0002. Repeat both requests again → LS now wins first.
- LS `lsAddr`=6'd37, Ack withheld for 5 cycles → `lsValid` and `lsData`=16'h2180 held stable for all 5 cycles. An IF request raised during RESP is not granted until after `lsAck`.
- `ifAddr`=6'd40 (out of TLB range) → `ifValid`=1, `ifData`=16'h0000.
- Spurious `lsAck` while IF owns RESP, and `ifAck` in IDLE → no state change, no Valid or Gnt change.
- Resetn pulled low in LOOKUP → all outputs 0 immediately, state IDLE. No response after release; a new IF request is granted with IF priority.
